// File: rtl/io_btn.sv
// io_btn: memory-mapped debounced push-button input with W1C press flags and press counters
module io_btn #(
    parameter int NBTN       = 3,
    parameter int DB_CYCLES  = 50000,
    parameter int DBW        = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [NBTN-1:0] btn_in,
    input  logic [3:0]  st_we_io,
    input  logic [9:0]  st_adr_io,
    input  logic [31:0] st_data_io,
    input  logic        ld_re_io,
    input  logic [9:0]  ld_adr_io,
    output logic [31:0] ld_data_io
);
    localparam int NPC = (NBTN < 4) ? NBTN : 4;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    logic [NBTN-1:0] r_s1, r_s2, r_stable, r_flags;
    logic [NBTN-1:0][DBW-1:0] r_db;
    logic [NPC-1:0][7:0] r_pc;
    logic r_clr;
    logic [NBTN-1:0] w_upd, w_press;
    logic w_st_flags, w_st_ctrl;
    logic [31:0] w_count, w_rd;
    logic w_unused;
    assign w_unused = &{1'b0, st_we_io[3:1], st_data_io};
    assign w_st_flags = st_we_io[0] && st_adr_io == 10'h1;
    assign w_st_ctrl = st_we_io[0] && st_adr_io == 10'h3;
    always_comb begin
        w_upd = '0;
        w_count = '0;
        for (int i = 0; i < NBTN; i++) w_upd[i] = (r_db[i] == DB_LAST) && (r_s2[i] != r_stable[i]);
        w_press = w_upd & r_s2;
        for (int i = 0; i < NPC; i++) w_count[8*i +: 8] = r_pc[i];
        w_rd = (ld_adr_io == 10'h0) ? 32'(r_stable) :
               (ld_adr_io == 10'h1) ? 32'(r_flags) :
               (ld_adr_io == 10'h2) ? w_count : 32'h0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_stable <= '0;
            r_db <= '0;
            r_flags <= '0;
            r_clr <= 1'b0;
            r_pc <= '0;
            ld_data_io <= '0;
        end else begin
            r_s1 <= (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
            r_s2 <= r_s1;
            for (int i = 0; i < NBTN; i++)
                r_db[i] <= (r_s2[i] == r_stable[i] || w_upd[i]) ? '0 : r_db[i] + 1'b1;
            r_stable <= r_stable ^ w_upd;
            // press sets after the clear so a same-cycle press survives the W1C store
            r_flags <= (w_st_flags ? (r_flags & ~st_data_io[NBTN-1:0]) : r_flags) | w_press;
            r_clr <= w_st_ctrl & st_data_io[0];
            for (int i = 0; i < NPC; i++)
                r_pc[i] <= r_clr ? 8'h0 : r_pc[i] + {7'h0, w_press[i]};
            if (ld_re_io) ld_data_io <= w_rd;
        end
    end
endmodule

// File: tb/tb_io_btn.sv
// tb_io_btn: directed scoreboard bench for io_btn with a short debounce period
module tb_io_btn;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  btn_in = 3'b111;
    logic [3:0]  st_we_io = '0;
    logic [9:0]  st_adr_io = '0;
    logic [31:0] st_data_io = '0;
    logic        ld_re_io = 1'b0;
    logic [9:0]  ld_adr_io = '0;
    logic [31:0] ld_data_io;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] q_exp[$];
    string q_name[$];

    io_btn #(.NBTN(3), .DB_CYCLES(4), .DBW(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .st_we_io(st_we_io), .st_adr_io(st_adr_io), .st_data_io(st_data_io),
        .ld_re_io(ld_re_io), .ld_adr_io(ld_adr_io), .ld_data_io(ld_data_io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: every accepted load is checked one edge later against the queued expectation
    initial forever begin
        @(posedge clk);
        if (rst_n && ld_re_io) begin
            #1;
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_load: got %h expected no load", ld_data_io);
            end else chk(q_name.pop_front(), ld_data_io, q_exp.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [9:0] adr, input logic [31:0] exp, input string n);
        ld_re_io = 1'b1;
        ld_adr_io = adr;
        q_exp.push_back(exp);
        q_name.push_back(n);
        @(negedge clk);
        ld_re_io = 1'b0;
    endtask

    task automatic wr(input logic [9:0] adr, input logic [31:0] d, input logic [3:0] we);
        st_we_io = we;
        st_adr_io = adr;
        st_data_io = d;
        @(negedge clk);
        st_we_io = '0;
    endtask

    task automatic press2;
        btn_in[2] = 1'b0;
        idle(7);
        btn_in[2] = 1'b1;
        idle(7);
    endtask

    initial begin
        idle(2);
        rst_n = 1'b1;
        chk("reset_ld_data", ld_data_io, 32'h0);
        rd(10'h0, 32'h0, "reset_level");
        rd(10'h1, 32'h0, "reset_flags");
        rd(10'h2, 32'h0, "reset_count");
        // button 0: level must flip between the 6th and 7th edge after the pin change
        btn_in[0] = 1'b0;
        idle(5);
        rd(10'h0, 32'h0, "level_edge6");
        rd(10'h0, 32'h1, "level_edge7");
        rd(10'h1, 32'h1, "flags_b0");
        rd(10'h2, 32'h1, "count_b0");
        // three-cycle glitch on button 1
        btn_in[1] = 1'b0;
        idle(3);
        btn_in[1] = 1'b1;
        idle(6);
        rd(10'h0, 32'h1, "glitch_level");
        rd(10'h1, 32'h1, "glitch_flags");
        rd(10'h2, 32'h1, "glitch_count");
        // real press of button 1, then W1C
        btn_in[1] = 1'b0;
        idle(8);
        rd(10'h1, 32'h3, "flags_b01");
        wr(10'h1, 32'h1, 4'b0001);
        rd(10'h1, 32'h2, "w1c_bit0");
        btn_in[1] = 1'b1;
        idle(8);
        // clear bit1 in the very cycle button 1 presses again: set wins
        btn_in[1] = 1'b0;
        idle(5);
        wr(10'h1, 32'h2, 4'b0001);
        rd(10'h1, 32'h2, "set_wins");
        rd(10'h2, 32'h0000_0201, "count_b1");
        // button 2 counter wrap
        for (int k = 0; k < 255; k++) press2();
        rd(10'h2, 32'h00FF_0201, "count_255");
        press2();
        rd(10'h2, 32'h0000_0201, "count_wrap");
        rd(10'h1, 32'h6, "flags_b2");
        wr(10'h3, 32'h1, 4'b0001);
        idle(1);
        rd(10'h2, 32'h0, "count_clr");
        rd(10'h3, 32'h0, "ctrl_read");
        // unmapped address, hold, ignored byte enables, RO level
        rd(10'h1, 32'h6, "flags_pre");
        rd(10'h5, 32'h0, "unmapped");
        rd(10'h1, 32'h6, "flags_again");
        idle(3);
        chk("hold_ld_data", ld_data_io, 32'h6);
        wr(10'h1, 32'h7, 4'b0010);
        rd(10'h1, 32'h6, "we_bit1_ignored");
        wr(10'h0, 32'h0, 4'b0001);
        rd(10'h0, 32'h3, "level_ro");
        wr(10'h1, 32'h7, 4'b0001);
        rd(10'h1, 32'h0, "flags_cleared");
        // reset mid-debounce of button 2
        btn_in[2] = 1'b0;
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rd(10'h0, 32'h0, "rst_mid_level");
        idle(6);
        rd(10'h0, 32'h7, "rst_relevel");
        for (int i = 0; i < 20 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_btn.md
Name: io_btn

Overview:
Memory-mapped push-button input peripheral on the CPU IO bus, the read-side counterpart of the LED output block.
- Synchronizes and debounces NBTN external buttons.
- Records press events in sticky write-1-to-clear flags and counts presses per button.
- Returns these values to the CPU load path with a fixed one-cycle read latency.

Parameters:
NBTN, 3, number of buttons, 1..8
DB_CYCLES, 50000, cycles a synchronized input must stay changed before the debounced level updates; >= 2
DBW, 16, debounce counter width; 2^DBW > DB_CYCLES
ACTIVE_LOW, 1, 1 = btn_in pins are active-low (inverted at input); 0 = active-high

Ports:
clk  input  1  system clock
rst_n  input  1  reset
btn_in  input  NBTN  raw asynchronous button pins
st_we_io  input  4  store byte enables; only bit 0 is used
st_adr_io  input  10  store word address [11:2]
st_data_io  input  32  store data
ld_re_io  input  1  load request, one-cycle pulse
ld_adr_io  input  10  load word address [11:2]
ld_data_io  output  32  load data, valid the cycle after ld_re_io

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All registers reset to 0, so ld_data_io = 0 after reset.
- Input path: polarity correction when ACTIVE_LOW = 1, then a 2-flop synchronizer per bit.
- Debounce, per button:
  - if sync == stable: counter cleared to 0.
  - else: counter increments; when counter == DB_CYCLES-1, stable <= sync and counter is cleared.
  - A change therefore propagates DB_CYCLES cycles after it reaches sync, i.e. DB_CYCLES+2 cycles after the pin changes.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
- Edge detect: press[i] = stable[i] rises (0 -> 1) in this cycle. Releases are not recorded.
- Register map (word address):
  - 0x0 LEVEL (RO): bits[NBTN-1:0] = stable; upper bits 0. Writes ignored.
  - 0x1 FLAGS (W1C): bit i set by press[i].
    - A store with st_we_io[0] = 1 clears each bit where st_data_io[i] = 1.
    - Set and clear of the same bit in the same cycle: set wins.
  - 0x2 COUNT (RO): byte i (bits 8i+7:8i, i < 4) = 8-bit press counter of button i.
    - Counts wrap 255 -> 0.
    - Buttons 4..7 have no counter; those bits read 0.
  - 0x3 CTRL (RW): bit0 = cnt_clr, self-clearing.
    - Writing 1 zeroes all press counters in the next cycle.
    - A press arriving in that same cycle is lost (clear wins).
    - Reads of CTRL return 0.
  - Other addresses: reads return 0, writes ignored.
- Store decode: a write takes effect only when st_we_io[0] = 1; st_we_io[3:1] are ignored.
- Read path:
  - ld_data_io is registered. On ld_re_io = 1 it loads the addressed value as it stood before that cycle's edge update.
  - With ld_re_io = 0, ld_data_io holds its last value.
- Reset mid-debounce discards counter and level. After release, stable = 0 and one debounce period must pass before a held button is reported.

Test Plan:
- Reset + ACTIVE_LOW = 1, DB_CYCLES = 4, btn_in = 3'b111 -> LEVEL reads 0, FLAGS 0, COUNT 0; ld_data_io = 0.
- btn_in[0] driven low and held -> LEVEL bit0 = 1 exactly 6 cycles after the pin edge; FLAGS = 0x1; COUNT = 0x00000001.
- btn_in[1] low for 3 cycles then high -> LEVEL, FLAGS and COUNT unchanged (glitch rejected).
- FLAGS = 0x3, store 0x1 to address 0x1 -> FLAGS = 0x2. Store 0x2 in the same cycle as a new press on button 1 -> FLAGS bit1 stays 1.
- 256 debounced presses on button 2 -> COUNT byte2 = 0x00 (wrap). Store 1 to CTRL -> COUNT = 0, next CTRL read = 0.
- ld_re_io with ld_adr_io = 0x5 -> ld_data_io = 0 next cycle. Store with st_we_io = 4'b0010 to FLAGS -> no change.
